adc_lvds_tx_emu: RTL and testbench

- ADC-side serializer: emulates the frame-clocked, two-lane-per-channel serial output of the 14-bit quad ADC.
- Drives the FPGA deserializer in loopback and simulation without the physical ADC.
- Takes parallel samples through a valid/ready handshake or from internal test patterns.
- Emits SDR lane bits plus a frame clock; a later OSERDES/OBUFDS stage converts them to LVDS.

---
 rtl/adc_emu_pkg.sv | 22 ++
 rtl/adc_lane_ser.sv | 36 +++
 rtl/adc_lvds_tx_emu.sv | 171 +++++++++++++++++
 tb/tb_adc_lvds_tx_emu.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the ADC LVDS transmit emulator.
package adc_emu_pkg;

  localparam int SAMPLE_W = 14;

  typedef enum logic [1:0] {
    PAT_USER  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FIXED = 2'd3
  } pat_t;

  localparam logic [SAMPLE_W-1:0] CHECK_A    = 14'h2AAA;
  localparam logic [SAMPLE_W-1:0] CHECK_B    = 14'h1555;
  localparam logic [SAMPLE_W-1:0] FIXED_WORD = 14'h2A5C;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/adc_lane_ser.sv
// Two-lane serializer for one channel: MSB pair first, odd bit on d1, even bit on d0.
module adc_lane_ser #(
  parameter int SAMPLE_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [SAMPLE_W-1:0] word,
  output logic                d0,
  output logic                d1
);

  logic [SAMPLE_W-1:0] sr;

  // Load presents the top bit pair immediately; shift walks down two bits per cycle; otherwise lanes idle low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
      d0 <= 1'b0;
      d1 <= 1'b0;
    end else if (load) begin
      d1 <= word[SAMPLE_W-1];
      d0 <= word[SAMPLE_W-2];
      sr <= {word[SAMPLE_W-3:0], 2'b00};
    end else if (shift) begin
      d1 <= sr[SAMPLE_W-1];
      d0 <= sr[SAMPLE_W-2];
      sr <= {sr[SAMPLE_W-3:0], 2'b00};
    end else begin
      d0 <= 1'b0;
      d1 <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_lvds_tx_emu.sv
// Frame-clocked two-lane-per-channel ADC output emulator.
// Optional macro ADC_TX_SKEW_EN adds a per-frame lane delay (skew input) for bitslip exercise.
module adc_lvds_tx_emu #(
  parameter int NUM_CH = 3,
  parameter int SAMPLE_W = adc_emu_pkg::SAMPLE_W,
  localparam int BITS_PER_LANE = SAMPLE_W / 2
) (
  input  logic                       clk_200m,
  input  logic                       rst_200m,
  input  logic                       tx_en,
  input  logic [1:0]                 pat_sel,
`ifdef ADC_TX_SKEW_EN
  input  logic [2:0]                 skew,
`endif
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic [NUM_CH-1:0]          lane_d0,
  output logic [NUM_CH-1:0]          lane_d1,
  output logic                       fclk,
  output logic                       underrun,
  output logic [31:0]                frame_cnt
);

  import adc_emu_pkg::*;

  localparam int CNT_W = (BITS_PER_LANE > 1) ? $clog2(BITS_PER_LANE) : 1;
  localparam int BUS_W = NUM_CH * SAMPLE_W;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_LANE - 1);
  localparam logic [CNT_W-1:0] FCLK_HI  = CNT_W'((BITS_PER_LANE + 1) / 2);
  localparam logic [SAMPLE_W-1:0] CHK_A_W = SAMPLE_W'(CHECK_A);
  localparam logic [SAMPLE_W-1:0] CHK_B_W = SAMPLE_W'(CHECK_B);
  localparam logic [SAMPLE_W-1:0] FIXED_W = SAMPLE_W'(FIXED_WORD);

  state_t              state, state_next;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_next;
  logic                frame_end, load, shift_en;
  logic [SAMPLE_W-1:0] ramp;
  logic                chk_phase;
  logic [BUS_W-1:0]    held, word_bus;
  logic [NUM_CH-1:0]   raw_d0, raw_d1;

  assign frame_end    = (state == RUN) && (bit_cnt == LAST_BIT);
  assign shift_en     = (state == RUN) && !frame_end;
  assign sample_ready = load && (pat_sel == PAT_USER);

  // Next state and bit counter; a load only happens when another frame will actually follow.
  always_comb begin
    state_next   = state;
    bit_cnt_next = '0;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (tx_en) load = 1'b1;
          else       state_next = IDLE;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Source mux: the word that the serializers pick up on a load cycle.
  always_comb begin
    word_bus = held;
    case (pat_t'(pat_sel))
      PAT_USER:  if (sample_valid) word_bus = sample_data;
      PAT_RAMP:  word_bus = {NUM_CH{ramp}};
      PAT_CHECK: word_bus = {NUM_CH{chk_phase ? CHK_B_W : CHK_A_W}};
      PAT_FIXED: word_bus = {NUM_CH{FIXED_W}};
      default:   word_bus = held;
    endcase
  end

  // State register, bit counter and frame clock, registered so fclk aligns with the lane bits.
  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m) begin
      state   <= IDLE;
      bit_cnt <= '0;
      fclk    <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      fclk    <= (state_next == RUN) && (bit_cnt_next < FCLK_HI);
    end
  end

  // Frame counter counts every frame that completes, including the last before stopping.
  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m)       frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 32'd1;
  end

  // Pattern generator state and held user sample, advanced only on load cycles.
  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m) begin
      held      <= '0;
      ramp      <= '0;
      chk_phase <= 1'b0;
      underrun  <= 1'b0;
    end else if (load) begin
      case (pat_t'(pat_sel))
        PAT_USER: begin
          if (sample_valid) held <= sample_data;
          else              underrun <= 1'b1;
        end
        PAT_RAMP:  ramp <= ramp + 1'b1;
        PAT_CHECK: chk_phase <= ~chk_phase;
        default:   ;
      endcase
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ser
    adc_lane_ser #(.SAMPLE_W(SAMPLE_W)) u_ser (
      .clk   (clk_200m),
      .rst   (rst_200m),
      .load  (load),
      .shift (shift_en),
      .word  (word_bus[ch*SAMPLE_W +: SAMPLE_W]),
      .d0    (raw_d0[ch]),
      .d1    (raw_d1[ch])
    );
  end

`ifdef ADC_TX_SKEW_EN
  localparam logic [2:0] SKEW_MAX = 3'(BITS_PER_LANE - 1);

  logic [2:0]        skew_q;
  logic [NUM_CH-1:0] dly_d0 [7];
  logic [NUM_CH-1:0] dly_d1 [7];

  // Skew is captured at frame boundaries only, clamped to one frame minus a bit.
  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m)  skew_q <= '0;
    else if (load) skew_q <= (skew > SKEW_MAX) ? SKEW_MAX : skew;
  end

  // Delay line keeps shifting in IDLE, so it drains to the idle-low lane value.
  always_ff @(posedge clk_200m or posedge rst_200m) begin
    if (rst_200m) begin
      for (int i = 0; i < 7; i++) begin
        dly_d0[i] <= '0;
        dly_d1[i] <= '0;
      end
    end else begin
      dly_d0[0] <= raw_d0;
      dly_d1[0] <= raw_d1;
      for (int i = 1; i < 7; i++) begin
        dly_d0[i] <= dly_d0[i-1];
        dly_d1[i] <= dly_d1[i-1];
      end
    end
  end

  assign lane_d0 = (skew_q == 3'd0) ? raw_d0 : dly_d0[skew_q - 3'd1];
  assign lane_d1 = (skew_q == 3'd0) ? raw_d1 : dly_d1[skew_q - 3'd1];
`else
  assign lane_d0 = raw_d0;
  assign lane_d1 = raw_d1;
`endif

endmodule

// File: tb/tb_adc_lvds_tx_emu.sv
// Directed bench for adc_lvds_tx_emu; a second narrow instance covers the ramp wrap quickly.
module tb_adc_lvds_tx_emu;

  localparam int NCH = 3;
  localparam int SW  = 14;
  localparam int BPL = 7;
  localparam int SSW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, tx_en, sample_valid;
  logic [1:0]        pat_sel;
  logic [NCH*SW-1:0] sample_data;
  logic              sample_ready, fclk, underrun;
  logic [NCH-1:0]    lane_d0, lane_d1;
  logic [31:0]       frame_cnt;

  logic              rst_s, tx_en_s, valid_s;
  logic [1:0]        pat_s;
  logic [SSW-1:0]    data_s;
  logic              ready_s, fclk_s, underrun_s;
  logic [0:0]        d0_s, d1_s;
  logic [31:0]       fcnt_s;

`ifdef ADC_TX_SKEW_EN
  logic [2:0] skew, skew_s;
`endif

  int tests = 0;
  int fails = 0;
  int exp_frames = 0;

  logic [SW-1:0]     fixed_w, chk_a, chk_b;
  logic [NCH*SW-1:0] d1_bus, d2_bus;

  adc_lvds_tx_emu #(.NUM_CH(NCH), .SAMPLE_W(SW)) dut (
    .clk_200m     (clk),
    .rst_200m     (rst),
    .tx_en        (tx_en),
    .pat_sel      (pat_sel),
`ifdef ADC_TX_SKEW_EN
    .skew         (skew),
`endif
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .lane_d0      (lane_d0),
    .lane_d1      (lane_d1),
    .fclk         (fclk),
    .underrun     (underrun),
    .frame_cnt    (frame_cnt)
  );

  adc_lvds_tx_emu #(.NUM_CH(1), .SAMPLE_W(SSW)) dut_s (
    .clk_200m     (clk),
    .rst_200m     (rst_s),
    .tx_en        (tx_en_s),
    .pat_sel      (pat_s),
`ifdef ADC_TX_SKEW_EN
    .skew         (skew_s),
`endif
    .sample_data  (data_s),
    .sample_valid (valid_s),
    .sample_ready (ready_s),
    .lane_d0      (d0_s),
    .lane_d1      (d1_s),
    .fclk         (fclk_s),
    .underrun     (underrun_s),
    .frame_cnt    (fcnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Precondition: outputs currently show bit 0 of a frame. Leaves them at bit 0 of the next frame.
  task automatic capture_frame(input logic [NCH*SW-1:0] exp_words, input string name);
    logic [NCH*SW-1:0] got;
    logic [6:0] fpat, rpat, rexp;
    logic [31:0] fc0;
    got = '0;
    fc0 = frame_cnt;
    for (int k = 0; k < BPL; k++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        got[ch*SW + 13 - 2*k] = lane_d1[ch];
        got[ch*SW + 12 - 2*k] = lane_d0[ch];
      end
      fpat[6-k] = fclk;
      rpat[6-k] = sample_ready;
      rexp[6-k] = (k == BPL-1) && tx_en && (pat_sel == 2'd0);
      tick();
    end
    tests++;
    if (got !== exp_words) begin
      fails++;
      $display("FAIL %s words: got %h expected %h", name, got, exp_words);
    end
    tests++;
    if (fpat !== 7'b1111000) begin
      fails++;
      $display("FAIL %s fclk: got %b expected 1111000", name, fpat);
    end
    tests++;
    if (rpat !== rexp) begin
      fails++;
      $display("FAIL %s ready: got %b expected %b", name, rpat, rexp);
    end
    tests++;
    if (fc0 !== 32'(exp_frames)) begin
      fails++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", name, fc0, exp_frames);
    end
    exp_frames++;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_en = 1'b0; pat_sel = 2'd0; sample_valid = 1'b0; sample_data = '0;
    repeat (3) tick();
    tests++;
    if ({lane_d0, lane_d1, fclk, sample_ready, underrun} !== '0 || frame_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset: got d0=%b d1=%b fclk=%b rdy=%b ur=%b fc=%0d expected all 0",
               lane_d0, lane_d1, fclk, sample_ready, underrun, frame_cnt);
    end
    rst = 1'b0;
    repeat (2) tick();
    tests++;
    if ({lane_d0, lane_d1, fclk, sample_ready} !== '0) begin
      fails++;
      $display("FAIL idle_hold: got d0=%b d1=%b fclk=%b rdy=%b expected 0",
               lane_d0, lane_d1, fclk, sample_ready);
    end
  endtask

  task automatic test_fixed();
    pat_sel = 2'd3; tx_en = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) capture_frame({NCH{fixed_w}}, "fixed");
  endtask

  task automatic test_user();
    pat_sel = 2'd0; sample_valid = 1'b1; sample_data = d1_bus;
    capture_frame({NCH{fixed_w}}, "fixed_to_user");
    capture_frame(d1_bus, "user_a");
    capture_frame(d1_bus, "user_b");
    tests++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL user_underrun: got %b expected 0", underrun);
    end
  endtask

  task automatic test_underrun();
    sample_valid = 1'b0; sample_data = d2_bus;
    capture_frame(d1_bus, "ur_last_good");
    tests++;
    if (underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_set: got %b expected 1", underrun);
    end
    sample_valid = 1'b1;
    capture_frame(d1_bus, "ur_repeat");
    pat_sel = 2'd2;
    capture_frame(d2_bus, "ur_recover");
    tests++;
    if (underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_sticky: got %b expected 1", underrun);
    end
  endtask

  task automatic test_checker();
    capture_frame({NCH{chk_a}}, "check_a");
    capture_frame({NCH{chk_b}}, "check_b");
    pat_sel = 2'd1;
    capture_frame({NCH{chk_a}}, "check_a2");
  endtask

  task automatic test_ramp();
    capture_frame({NCH{14'd0}}, "ramp0");
    capture_frame({NCH{14'd1}}, "ramp1");
    pat_sel = 2'd3;
    capture_frame({NCH{14'd2}}, "ramp2");
  endtask

  task automatic test_stop_and_reset();
    logic [NCH*SW-1:0] got;
    logic rdy6;
    got = '0;
    rdy6 = 1'b0;
    for (int k = 0; k < BPL; k++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        got[ch*SW + 13 - 2*k] = lane_d1[ch];
        got[ch*SW + 12 - 2*k] = lane_d0[ch];
      end
      if (k == BPL-1) rdy6 = sample_ready;
      if (k == 2) tx_en = 1'b0;
      tick();
    end
    tests++;
    if (got !== {NCH{fixed_w}} || rdy6 !== 1'b0) begin
      fails++;
      $display("FAIL stop_frame: got %h rdy=%b expected %h rdy=0", got, rdy6, {NCH{fixed_w}});
    end
    tests++;
    if ({lane_d0, lane_d1, fclk} !== '0 || frame_cnt !== 32'(exp_frames + 1)) begin
      fails++;
      $display("FAIL stop_idle: got d0=%b d1=%b fclk=%b fc=%0d expected 0 fc=%0d",
               lane_d0, lane_d1, fclk, frame_cnt, exp_frames + 1);
    end
    repeat (10) tick();
    tests++;
    if ({lane_d0, lane_d1, fclk} !== '0 || frame_cnt !== 32'(exp_frames + 1)) begin
      fails++;
      $display("FAIL stop_frozen: got d0=%b d1=%b fclk=%b fc=%0d expected 0 fc=%0d",
               lane_d0, lane_d1, fclk, frame_cnt, exp_frames + 1);
    end
    tx_en = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({lane_d0, lane_d1, fclk, sample_ready, underrun} !== '0 || frame_cnt !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: got d0=%b d1=%b fclk=%b rdy=%b ur=%b fc=%0d expected all 0",
               lane_d0, lane_d1, fclk, sample_ready, underrun, frame_cnt);
    end
    tx_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp_wrap();
    logic [SSW-1:0] got;
    logic [2:0] fpat;
    rst_s = 1'b0; tx_en_s = 1'b1;
    tick();
    for (int n = 0; n < 66; n++) begin
      got = '0;
      for (int k = 0; k < 3; k++) begin
        got[5 - 2*k] = d1_s[0];
        got[4 - 2*k] = d0_s[0];
        fpat[2-k] = fclk_s;
        tick();
      end
      tests++;
      if (got !== SSW'(n % 64)) begin
        fails++;
        $display("FAIL ramp_wrap frame %0d: got %0d expected %0d", n, got, n % 64);
      end
      if (n == 0) begin
        tests++;
        if (fpat !== 3'b110) begin
          fails++;
          $display("FAIL ramp_wrap fclk: got %b expected 110", fpat);
        end
      end
    end
    tests++;
    if (fcnt_s !== 32'd66 || underrun_s !== 1'b0 || ready_s !== 1'b0) begin
      fails++;
      $display("FAIL ramp_wrap status: got fc=%0d ur=%b rdy=%b expected fc=66 ur=0 rdy=0",
               fcnt_s, underrun_s, ready_s);
    end
    tx_en_s = 1'b0;
  endtask

`ifdef ADC_TX_SKEW_EN
  task automatic test_skew();
    int j;
    logic b1, b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; skew = 3'd3; pat_sel = 2'd3; tx_en = 1'b1;
    tick();
    repeat (BPL) tick();
    for (int k = 0; k < BPL; k++) begin
      j  = (k + BPL - 3) % BPL;
      b1 = fixed_w[13 - 2*j];
      b0 = fixed_w[12 - 2*j];
      tests++;
      if (lane_d1 !== {NCH{b1}} || lane_d0 !== {NCH{b0}} || fclk !== (k < 4)) begin
        fails++;
        $display("FAIL skew bit %0d: got d1=%b d0=%b fclk=%b expected d1=%b d0=%b fclk=%b",
                 k, lane_d1, lane_d0, fclk, {NCH{b1}}, {NCH{b0}}, (k < 4));
      end
      tick();
    end
    tx_en = 1'b0;
  endtask
`endif

  initial begin
    fixed_w = 14'h2A5C;
    chk_a   = 14'h2AAA;
    chk_b   = 14'h1555;
    d1_bus  = {14'h2AAA, 14'h0000, 14'h3FFF};
    d2_bus  = {14'h1234, 14'h0ABC, 14'h1555};
    rst_s = 1'b1; tx_en_s = 1'b0; pat_s = 2'd1; valid_s = 1'b0; data_s = '0;
`ifdef ADC_TX_SKEW_EN
    skew = 3'd0; skew_s = 3'd0;
`endif
    test_reset();
    test_fixed();
    test_user();
    test_underrun();
    test_checker();
    test_ramp();
    test_stop_and_reset();
    test_ramp_wrap();
`ifdef ADC_TX_SKEW_EN
    test_skew();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
